// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state codes and the per-stage control vector.
// The control vector bit positions are also used by the pipeline register modules.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_e;

    localparam int CTRL_W             = 6;
    localparam int CTRL_PC_WRITE      = 5;
    localparam int CTRL_IF_ID_WRITE   = 4;
    localparam int CTRL_IF_ID_FLUSH   = 3;
    localparam int CTRL_ID_EX_BUBBLE  = 2;
    localparam int CTRL_EX_MEM_WRITE  = 1;
    localparam int CTRL_MEM_WB_BUBBLE = 0;

    // Field order matches the CTRL_* bit positions above (MSB first).
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_HALT   = '0;
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      id_ex_bubble: 1'b0, ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};

    // Decode for a cycle in which memory is not holding the pipeline: load-use beats branch.
    function automatic ctrl_t run_ctrl(input logic load_use, input logic branch_taken);
        ctrl_t c;
        c = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
              id_ex_bubble: 1'b0, ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};
        if (load_use) begin
            c.pc_write     = 1'b0;
            c.if_id_write  = 1'b0;
            c.id_ex_bubble = 1'b1;
        end else if (branch_taken) begin
            c.if_id_flush  = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// q_o holds at MAX once reached; max_o flags that value.
module pipeline_stall_ctrl_sat_counter #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o,
    output logic         max_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !max_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign q_o   = cnt_q;
    assign max_o = (cnt_q == MAX);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: merges memory wait, load-use and taken-branch into per-stage controls.
// Outputs are Mealy (state + current inputs); memory waits are bounded by MEM_TIMEOUT, stalls counted.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_bubble_o,
    output logic             error_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);

    state_e              state_q;
    state_e              state_d;
    ctrl_t               ctrl;
    logic                freeze;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_last;
    logic                wait_clr;
    logic                stall_max;
    logic                stall_inc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_HALT;
        freeze  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    ctrl    = CTRL_FREEZE;
                    freeze  = 1'b1;
                    state_d = ST_MEM_WAIT;
                end else begin
                    ctrl = run_ctrl(load_use_i, branch_taken_i);
                end
            end
            ST_MEM_WAIT: begin
                // ID is held while frozen, so hazards seen now are re-presented after release.
                if (!mem_ack_i) begin
                    ctrl   = CTRL_FREEZE;
                    freeze = 1'b1;
                    if (wait_last) begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    ctrl    = run_ctrl(load_use_i, branch_taken_i);
                    state_d = ST_RUN;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Wait count reads 1 on the first frozen cycle after entering MEM_WAIT; cleared whenever leaving.
    assign wait_clr = rst_i || (state_d != ST_MEM_WAIT);

    pipeline_stall_ctrl_sat_counter #(
        .W   (WAIT_W),
        .MAX (WAIT_W'(MEM_TIMEOUT - 1))
    ) u_wait_cnt (
        .clk_i (clk_i),
        .clr_i (wait_clr),
        .inc_i (freeze),
        .q_o   (wait_cnt),
        .max_o (wait_last)
    );

    assign stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT))
                       && !ctrl.pc_write && !stall_max;

    pipeline_stall_ctrl_sat_counter #(
        .W   (CNT_W),
        .MAX ({CNT_W{1'b1}})
    ) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (stall_inc),
        .q_o   (stall_cnt_o),
        .max_o (stall_max)
    );

    assign pc_write_o      = ctrl.pc_write;
    assign if_id_write_o   = ctrl.if_id_write;
    assign if_id_flush_o   = ctrl.if_id_flush;
    assign id_ex_bubble_o  = ctrl.id_ex_bubble;
    assign ex_mem_write_o  = ctrl.ex_mem_write;
    assign mem_wb_bubble_o = ctrl.mem_wb_bubble;
    assign error_o         = (state_q == ST_ERROR);

    logic unused_wait;
    assign unused_wait = ^wait_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: a MEM_TIMEOUT=4 instance plus a CNT_W=2 instance on shared inputs.
module tb_pipeline_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        load_use;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ack;

    logic        pc_w, ifid_w, ifid_f, idex_b, exmem_w, memwb_b, err;
    logic [15:0] scnt;
    logic        s_pc_w, s_ifid_w, s_ifid_f, s_idex_b, s_exmem_w, s_memwb_b, s_err;
    logic [1:0]  s_scnt;

    logic [5:0]  ctl;
    logic [5:0]  s_ctl;

    int checks = 0;
    int errors = 0;

    assign ctl   = {pc_w, ifid_w, ifid_f, idex_b, exmem_w, memwb_b};
    assign s_ctl = {s_pc_w, s_ifid_w, s_ifid_f, s_idex_b, s_exmem_w, s_memwb_b};

    localparam logic [5:0] C_HALT   = 6'b000000;
    localparam logic [5:0] C_RUN    = 6'b110010;
    localparam logic [5:0] C_LU     = 6'b000110;
    localparam logic [5:0] C_BR     = 6'b111010;
    localparam logic [5:0] C_FREEZE = 6'b000001;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .load_use_i(load_use),
        .branch_taken_i(branch_taken), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_write_o(pc_w), .if_id_write_o(ifid_w), .if_id_flush_o(ifid_f),
        .id_ex_bubble_o(idex_b), .ex_mem_write_o(exmem_w), .mem_wb_bubble_o(memwb_b),
        .error_o(err), .stall_cnt_o(scnt)
    );

    pipeline_stall_ctrl #(.MEM_TIMEOUT(16), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start), .load_use_i(load_use),
        .branch_taken_i(branch_taken), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_write_o(s_pc_w), .if_id_write_o(s_ifid_w), .if_id_flush_o(s_ifid_f),
        .id_ex_bubble_o(s_idex_b), .ex_mem_write_o(s_exmem_w), .mem_wb_bubble_o(s_memwb_b),
        .error_o(s_err), .stall_cnt_o(s_scnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic lu, input logic br, input logic rq, input logic ak);
        start = s; load_use = lu; branch_taken = br; mem_req = rq; mem_ack = ak;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ctl !== C_HALT) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_HALT); end
        checks++;
        if (scnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", scnt); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", err); end
    endtask

    task automatic test_start();
        set_in(1, 0, 0, 1, 0);
        checks++;
        if (ctl !== C_HALT) begin errors++; $display("FAIL idle_ctl got=%b exp=%b", ctl, C_HALT); end
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (ctl !== C_RUN) begin errors++; $display("FAIL run_ctl got=%b exp=%b", ctl, C_RUN); end
        checks++;
        if (scnt !== 16'd0) begin errors++; $display("FAIL run_stall_cnt got=%0d exp=0", scnt); end
    endtask

    task automatic test_load_use();
        set_in(0, 1, 0, 0, 0);
        checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL load_use_ctl got=%b exp=%b", ctl, C_LU); end
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (scnt !== 16'd1) begin errors++; $display("FAIL load_use_cnt got=%0d exp=1", scnt); end
        checks++;
        if (ctl !== C_RUN) begin errors++; $display("FAIL load_use_after got=%b exp=%b", ctl, C_RUN); end
    endtask

    // Ack arrives on the last wait cycle before timeout (wait count 3 of MEM_TIMEOUT=4).
    task automatic test_mem_wait();
        set_in(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl !== C_FREEZE) begin errors++; $display("FAIL mem_wait_freeze%0d got=%b exp=%b", i, ctl, C_FREEZE); end
            tick();
        end
        set_in(0, 0, 0, 1, 1);
        checks++;
        if (ctl !== C_RUN) begin errors++; $display("FAIL mem_ack_ctl got=%b exp=%b", ctl, C_RUN); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL mem_ack_err got=%b exp=0", err); end
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (ctl !== C_RUN) begin errors++; $display("FAIL mem_release_ctl got=%b exp=%b", ctl, C_RUN); end
        checks++;
        if (scnt !== 16'd4) begin errors++; $display("FAIL mem_wait_cnt got=%0d exp=4", scnt); end
    endtask

    task automatic test_lu_branch();
        set_in(0, 1, 1, 0, 0);
        checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL lu_br_ctl got=%b exp=%b", ctl, C_LU); end
        tick();
        set_in(0, 0, 1, 0, 0);
        checks++;
        if (ctl !== C_BR) begin errors++; $display("FAIL branch_ctl got=%b exp=%b", ctl, C_BR); end
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (scnt !== 16'd5) begin errors++; $display("FAIL lu_br_cnt got=%0d exp=5", scnt); end
    endtask

    task automatic test_single_cycle_mem();
        set_in(0, 0, 1, 1, 1);
        checks++;
        if (ctl !== C_BR) begin errors++; $display("FAIL single_mem_ctl got=%b exp=%b", ctl, C_BR); end
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (ctl !== C_RUN || scnt !== 16'd5) begin
            errors++; $display("FAIL single_mem_after ctl=%b cnt=%0d exp ctl=%b cnt=5", ctl, scnt, C_RUN);
        end
    endtask

    task automatic test_hazard_in_wait();
        set_in(0, 1, 0, 1, 0);
        checks++;
        if (ctl !== C_FREEZE) begin errors++; $display("FAIL mem_over_lu got=%b exp=%b", ctl, C_FREEZE); end
        tick();
        set_in(0, 1, 1, 1, 0);
        checks++;
        if (ctl !== C_FREEZE) begin errors++; $display("FAIL wait_ignores_hazard got=%b exp=%b", ctl, C_FREEZE); end
        tick();
        set_in(0, 1, 0, 1, 1);
        checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL ack_with_lu got=%b exp=%b", ctl, C_LU); end
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (ctl !== C_RUN || scnt !== 16'd8) begin
            errors++; $display("FAIL hazard_wait_after ctl=%b cnt=%0d exp ctl=%b cnt=8", ctl, scnt, C_RUN);
        end
    endtask

    task automatic test_timeout();
        set_in(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctl !== C_FREEZE || err !== 1'b0) begin
                errors++; $display("FAIL timeout_frozen%0d ctl=%b err=%b exp ctl=%b err=0", i, ctl, err, C_FREEZE);
            end
            tick();
        end
        set_in(1, 1, 1, 1, 1);
        checks++;
        if (err !== 1'b1 || ctl !== C_HALT) begin
            errors++; $display("FAIL timeout_error err=%b ctl=%b exp err=1 ctl=%b", err, ctl, C_HALT);
        end
        checks++;
        if (s_err !== 1'b0) begin errors++; $display("FAIL long_timeout_err got=%b exp=0", s_err); end
        tick();
        tick();
        checks++;
        if (err !== 1'b1 || ctl !== C_HALT || scnt !== 16'd12) begin
            errors++; $display("FAIL error_sticky err=%b ctl=%b cnt=%0d exp err=1 ctl=%b cnt=12", err, ctl, scnt, C_HALT);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 0);
        tick();
        checks++;
        if (ctl !== C_FREEZE || scnt !== 16'd1) begin
            errors++; $display("FAIL pre_reset_wait ctl=%b cnt=%0d exp ctl=%b cnt=1", ctl, scnt, C_FREEZE);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 1, 0);
        checks++;
        if (ctl !== C_HALT || scnt !== 16'd0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_in_wait ctl=%b cnt=%0d err=%b exp ctl=%b cnt=0 err=0", ctl, scnt, err, C_HALT);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 1, 0, 0, 0);
        checks++;
        if (s_ctl !== C_LU) begin errors++; $display("FAIL sat_lu_ctl got=%b exp=%b", s_ctl, C_LU); end
        for (int i = 0; i < 5; i++) tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (s_scnt !== 2'd3) begin errors++; $display("FAIL stall_saturate got=%0d exp=3", s_scnt); end
        checks++;
        if (scnt !== 16'd5) begin errors++; $display("FAIL stall_wide got=%0d exp=5", scnt); end
        checks++;
        if (s_ctl !== C_RUN || s_err !== 1'b0) begin
            errors++; $display("FAIL sat_after ctl=%b err=%b exp ctl=%b err=0", s_ctl, s_err, C_RUN);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        test_reset();
        test_start();
        test_load_use();
        test_mem_wait();
        test_lu_branch();
        test_single_cycle_mem();
        test_hazard_in_wait();
        test_timeout();
        test_reset_in_wait();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
